dut_out_packer: RTL
===================

# dut_out_packer

Downstream stage of the DUT wrapper on the XDMA side. Captures each `out_enable`-qualified 4064-bit DUT output word, prepends a 32-bit header, and serialises the 4096-bit frame into eight 512-bit AXI4-Stream beats toward the XDMA C2H channel. A two-frame buffer absorbs host back-pressure. Frames that arrive while both slots are full are dropped and counted.

## Interface
- `IN_WIDTH`, default 4064: DUT output word width. `IN_WIDTH + 32` must be a multiple of `BEAT_WIDTH`.
- `BEAT_WIDTH`, default 512: AXI-Stream data width.
- `NBEATS`, derived as `(IN_WIDTH+32)/BEAT_WIDTH` (8 at defaults). Not overridable.

- `xdma_clk`  in  1  sole clock.
- `xdma_reset`  in  1  reset; synchronous, active-high.
- `in_enable`  in  1  frame-valid strobe; driven by `out_enable`.
- `in_data`  in  IN_WIDTH  DUT output word; driven by `out_io_data`.
- `m_axis_c2h_tdata`  out  BEAT_WIDTH  stream data.
- `m_axis_c2h_tkeep`  out  BEAT_WIDTH/8  stream byte enables; constant all-ones.
- `m_axis_c2h_tlast`  out  1  high on the last beat of each frame.
- `m_axis_c2h_tvalid`  out  1  stream valid.
- `m_axis_c2h_tready`  in  1  stream ready.
- `drop_cnt`  out  32  frames dropped; saturates at 0xFFFF_FFFF.
- `overflow`  out  1  sticky; set on the first drop.

## Operation
- **Frame format:** frame = `{in_data, hdr[31:0]}`. Beat k carries `frame[BEAT_WIDTH*k +: BEAT_WIDTH]`, k = 0..NBEATS-1. Beat 0 is sent first.
- **Buffer:** 2 slots, `wr_ptr`, `rd_ptr` (1 bit each), `count` 0..2.
- **Capture:** on a cycle with `in_enable=1`:
  - If `count<2`, or the final beat of the head frame handshakes in the same cycle, write the frame to `slot[wr_ptr]`, toggle `wr_ptr`, and increment `seq`.
  - Otherwise drop the frame: `drop_cnt` increments (saturating) and `overflow` is set.
- **Output FSM:**
  - IDLE: if `count>0`, go to SEND with `beat=0`.
  - SEND: on each handshake, `beat++`. On the handshake with `beat==NBEATS-1`: toggle `rd_ptr`, decrement `count`, set `beat=0`. Stay in SEND if another frame is queued, including one captured this cycle; otherwise go to IDLE.
- **Count update:** simultaneous capture and frame completion leaves `count` unchanged.
- **Sequence counter:** `seq` is 32 bits and wraps 0xFFFF_FFFF → 0. It counts accepted frames only.

## Timing
- **Reset values:** `tvalid=0`, `tlast=0`, `tdata=0`, `drop_cnt=0`, `overflow=0`, `count=0`, `seq=0`, both pointers 0, FSM in IDLE.
- **Reset mid-frame:** the partial frame and any buffered frame are discarded. `tvalid` is 0 the cycle after reset is sampled.
- **Latency:** `in_enable` at cycle N with an empty buffer gives beat 0 valid at N+1.
- **Throughput:** with `tready` held high, one beat per cycle and no gap between back-to-back frames.
- **Sustained rate:** one frame per NBEATS cycles at `tready=1`. Faster `in_enable` strobes eventually overflow the buffer.
- **Handshake rules:**
  - A beat transfers when `tvalid && tready`.
  - While `tvalid && !tready`, `tdata`, `tlast` and `tvalid` hold stable.
  - `tvalid` never depends combinationally on `tready`.
- **Outputs:** all outputs are registered. `in_data` is sampled only when `in_enable=1`.

## Configuration
- `DUT_OUT_PACKER_SEQ_HDR_EN`
  - **Defined:** `hdr = seq` (value before increment). The first frame after reset carries header 0.
  - **Undefined:** `hdr = 32'h0`, and the `seq` register is not implemented. All other behaviour is identical.

## Test plan
- **Single frame:** reset, then one `in_enable` with `in_data` = incrementing byte pattern, `tready=1` → 8 beats on consecutive cycles starting N+1. Beat 0 low 32 bits = 0. `tlast` only on beat 7. Reassembled frame matches input.
- **Back-pressure hold:** `tready` toggles 1/0 each cycle during a frame → every beat is held stable while stalled, no beat is lost or duplicated, 16 cycles total.
- **Overflow:** `tready=0`, three `in_enable` strobes → two frames buffered, `drop_cnt=1`, `overflow=1`. After `tready=1`, exactly 16 beats emerge with headers 0 and 1.
- **Simultaneous capture and free:** `count=2` and `in_enable` in the same cycle as the final beat handshake → frame accepted, `drop_cnt` unchanged, no idle cycle between frames.
- **Reset mid-frame:** assert `xdma_reset` after beat 3 → `tvalid=0` the next cycle. A new frame afterwards starts at beat 0 with header 0.
- **Header wrap (macro defined):** force `seq=0xFFFF_FFFF`, send two frames → headers 0xFFFF_FFFF then 0x0000_0000. With the macro undefined, both headers are 0.

Source files
------------

// File: rtl/dut_out_packer.sv
// rtl/dut_out_packer.sv - header-prefixed DUT word to multi-beat AXI-Stream packer, two-frame buffer
// Optional macro DUT_OUT_PACKER_SEQ_HDR_EN: header carries the accepted-frame sequence number.
module dut_out_packer #(
  parameter int IN_WIDTH   = 4064,
  parameter int BEAT_WIDTH = 512
) (
  input  logic                    xdma_clk,
  input  logic                    xdma_reset,
  input  logic                    in_enable,
  input  logic [IN_WIDTH-1:0]     in_data,
  output logic [BEAT_WIDTH-1:0]   m_axis_c2h_tdata,
  output logic [BEAT_WIDTH/8-1:0] m_axis_c2h_tkeep,
  output logic                    m_axis_c2h_tlast,
  output logic                    m_axis_c2h_tvalid,
  input  logic                    m_axis_c2h_tready,
  output logic [31:0]             drop_cnt,
  output logic                    overflow
);
  localparam int NBEATS = (IN_WIDTH + 32) / BEAT_WIDTH;
  localparam int BIDX   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BIDX-1:0] LAST_BEAT = BIDX'(NBEATS - 1);

  typedef logic [NBEATS-1:0][BEAT_WIDTH-1:0] frame_t;
  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  frame_t                slot_q [2];
  frame_t                new_frame, head_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic [BIDX-1:0]       beat_q, beat_d;
  logic [BEAT_WIDTH-1:0] tdata_q;
  logic                  tvalid_q, tlast_q;
  logic [31:0]           drop_cnt_q;
  logic                  overflow_q;
  logic [31:0]           hdr;
  logic                  fire, last_fire, accept, drop;

`ifdef DUT_OUT_PACKER_SEQ_HDR_EN
  logic [31:0] seq_q;

  always_ff @(posedge xdma_clk) begin
    if (xdma_reset) begin
      seq_q <= '0;
    end else if (accept) begin
      seq_q <= seq_q + 32'd1;
    end
  end

  assign hdr = seq_q;
`else
  assign hdr = 32'h0;
`endif

  assign new_frame = {in_data, hdr};
  assign fire      = tvalid_q && m_axis_c2h_tready;
  assign last_fire = fire && tlast_q;
  // A slot freed by this cycle's final handshake can be refilled in the same cycle.
  assign accept    = in_enable && ((count_q != 2'd2) || last_fire);
  assign drop      = in_enable && !accept;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ accept;
    rd_ptr_d = rd_ptr_q ^ last_fire;
    count_d  = count_q + 2'(accept) - 2'(last_fire);
    beat_d   = beat_q;
    if (fire) begin
      beat_d = last_fire ? '0 : beat_q + 1'b1;
    end
    state_d  = (count_d != 2'd0) ? SEND : IDLE;
    // The frame being written this cycle becomes head when it lands in the next-read slot.
    if (accept && (wr_ptr_q == rd_ptr_d)) begin
      head_d = new_frame;
    end else begin
      head_d = slot_q[rd_ptr_d];
    end
  end

  always_ff @(posedge xdma_clk) begin
    if (accept) begin
      slot_q[wr_ptr_q] <= new_frame;
    end
  end

  always_ff @(posedge xdma_clk) begin
    if (xdma_reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      beat_q     <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      beat_q   <= beat_d;
      tvalid_q <= (state_d == SEND);
      tlast_q  <= (state_d == SEND) && (beat_d == LAST_BEAT);
      tdata_q  <= (state_d == SEND) ? head_d[beat_d] : '0;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) begin
          drop_cnt_q <= drop_cnt_q + 32'd1;
        end
      end
    end
  end

  assign m_axis_c2h_tdata  = tdata_q;
  assign m_axis_c2h_tkeep  = '1;
  assign m_axis_c2h_tlast  = tlast_q;
  assign m_axis_c2h_tvalid = tvalid_q;
  assign drop_cnt          = drop_cnt_q;
  assign overflow          = overflow_q;

endmodule
